// File: rtl/mix_scheduler.sv
// Drives the shared mix_forward datapath through F_MIX1..F_MIX3 for one hidden vector,
// chaining each layer's q into the next layer's d and handing the final result downstream.
module mix_scheduler #(
  parameter int D_W     = 32,
  parameter int ST_W    = 4,
  parameter int ST_IDLE = 0,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_ready,
  input  logic [D_W-1:0]   in_d,
  input  logic             abort,
  output logic [ST_W-1:0]  mix_state,
  output logic             mix_run,
  output logic [D_W-1:0]   mix_d,
  input  logic             mix_valid,
  input  logic [D_W-1:0]   mix_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_W-1:0]   out_q,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int RC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        layer_q, layer_d;
  logic [D_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [RC_W-1:0]   run_cnt_q, run_cnt_d;
  logic [ST_W-1:0]   mix_state_q, mix_state_d;
  logic              mix_run_q, mix_run_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              start_ready_q, start_ready_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    run_cnt_d   = run_cnt_q;
    mix_state_d = mix_state_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      mix_state_d = ST_W'(ST_IDLE);
      out_valid_d = 1'b0;
      run_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            buf_d       = in_d;
            layer_d     = 2'd0;
            cnt_d       = '0;
            state_d     = SETUP;
            mix_state_d = ST_W'(1);
          end
        end
        SETUP: begin
          cnt_d     = sat_inc(cnt_q);
          run_cnt_d = '0;
          state_d   = RUN;
        end
        RUN: begin
          cnt_d = sat_inc(cnt_q);
          if (mix_valid) begin
            buf_d     = mix_q;
            run_cnt_d = '0;
            if (layer_q < 2'd2) begin
              layer_d     = layer_q + 2'd1;
              state_d     = SETUP;
              mix_state_d = ST_W'(layer_q) + ST_W'(2);
            end else begin
              state_d     = DONE;
              mix_state_d = ST_W'(ST_IDLE);
              out_valid_d = 1'b1;
              // Reported span runs from the start cycle through the first out_valid cycle.
              cycles_d    = sat_inc(sat_inc(cnt_q));
            end
          end else if (run_cnt_q == RC_W'(TIMEOUT - 1)) begin
            err_d       = 1'b1;
            state_d     = IDLE;
            mix_state_d = ST_W'(ST_IDLE);
            run_cnt_d   = '0;
          end else begin
            run_cnt_d = run_cnt_q + RC_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mix_run_d     = (state_d == RUN);
    start_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      layer_q       <= 2'd0;
      buf_q         <= '0;
      cnt_q         <= '0;
      cycles_q      <= '0;
      run_cnt_q     <= '0;
      mix_state_q   <= ST_W'(ST_IDLE);
      mix_run_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      cycles_q      <= cycles_d;
      run_cnt_q     <= run_cnt_d;
      mix_state_q   <= mix_state_d;
      mix_run_q     <= mix_run_d;
      out_valid_q   <= out_valid_d;
      err_q         <= err_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign mix_state   = mix_state_q;
  assign mix_run     = mix_run_q;
  assign mix_d       = buf_q;
  assign out_q       = buf_q;
  assign out_valid   = out_valid_q;
  assign err         = err_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler with a stub datapath returning q=d+1 a set number of run cycles in.
module tb_mix_scheduler;
  localparam int D_W     = 32;
  localparam int ST_W    = 4;
  localparam int TIMEOUT = 1023;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, start_ready, abort;
  logic [D_W-1:0]   in_d, mix_d, mix_q, out_q;
  logic [ST_W-1:0]  mix_state;
  logic             mix_run, mix_valid, out_valid, out_ready, err;
  logic [CNT_W-1:0] cycles;

  int n_vec = 0;
  int n_bad = 0;

  // stub controls
  int              stub_lat  = 8;
  logic [ST_W-1:0] stub_dead = '0;
  logic            spur      = 1'b0;
  int              scnt      = 0;

  // monitor state
  logic [ST_W-1:0] seq[$];
  int              gaps[$];
  int              gap      = 0;
  logic            prev_run = 1'b0;
  int              err_cnt  = 0;

  mix_scheduler #(.D_W(D_W), .ST_W(ST_W), .ST_IDLE(0), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .in_d(in_d),
    .abort(abort), .mix_state(mix_state), .mix_run(mix_run), .mix_d(mix_d),
    .mix_valid(mix_valid), .mix_q(mix_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .err(err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst || !mix_run) begin
      scnt      = 0;
      mix_valid = spur;
    end else begin
      scnt      = scnt + 1;
      mix_valid = spur || ((scnt == stub_lat) && (mix_state != stub_dead));
    end
    mix_q = mix_d + 1;
  end

  always @(negedge clk) begin
    if (mix_run && !prev_run) begin
      seq.push_back(mix_state);
      gaps.push_back(gap);
    end
    if (mix_run) gap = 0;
    else         gap = gap + 1;
    prev_run = mix_run;
    if (err) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start with d, then count negedges until out_valid or err (bounded).
  task automatic launch(input logic [D_W-1:0] d, input int budget, output int n);
    in_d  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!out_valid && !err && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_run(input logic [ST_W-1:0] st, input int budget, output bit ok);
    int n;
    n = 0;
    while (!(mix_run && mix_state == st) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (mix_run && mix_state == st);
  endtask

  initial begin
    int lat, n, e0;
    bit ok;
    rst = 1'b1; start = 1'b0; in_d = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_run", mix_run, 0);
    chk("rst_state", mix_state, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_ready", start_ready, 1);
    chk("rst_buf", mix_d, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three layers, 8-cycle stub
    seq.delete(); gaps.delete();
    launch(32'h1234_0000, 200, lat);
    chk("t1_lat", lat, 28);
    chk("t1_outq", out_q, 32'h1234_0003);
    chk("t1_cycles", cycles, 28);
    chk("t1_nlayers", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("t1_layer1", seq[0], 1);
      chk("t1_layer2", seq[1], 2);
      chk("t1_layer3", seq[2], 3);
      chk("t1_gap12", gaps[1], 1);
      chk("t1_gap23", gaps[2], 1);
    end
    chk("t1_done_run", mix_run, 0);
    chk("t1_done_state", mix_state, 0);

    // 2: hold result while consumer stalls
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_ovld", out_valid, 1);
      chk("t2_outq", out_q, 32'h1234_0003);
      chk("t2_ready", start_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_ovld_drop", out_valid, 0);
    chk("t2_idle", start_ready, 1);

    // 3: layer 2 never completes
    stub_dead = 4'd2;
    in_d = 32'h0000_0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run(4'd2, 100, ok);
    chk("t3_reach_l2", ok, 1);
    n = 0;
    while (!err && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_to_dist", n, TIMEOUT);
    chk("t3_run", mix_run, 0);
    chk("t3_ovld", out_valid, 0);
    chk("t3_ready", start_ready, 1);
    chk("t3_buf", mix_d, 32'h0000_0101);
    @(negedge clk);
    chk("t3_err_pulse", err, 0);
    stub_dead = '0;

    // 4: abort in layer 1 RUN, then abort racing a start, then a clean run
    in_d = 32'h0000_0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run(4'd1, 100, ok);
    chk("t4_reach_l1", ok, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_run", mix_run, 0);
    chk("t4_state", mix_state, 0);
    chk("t4_ready", start_ready, 1);
    start = 1'b1; abort = 1'b1; in_d = 32'h0000_0999;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t4_race_state", mix_state, 0);
    chk("t4_race_ready", start_ready, 1);
    launch(32'h0000_0300, 200, lat);
    chk("t4_lat", lat, 28);
    chk("t4_outq", out_q, 32'h0000_0303);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // 5: valid arrives exactly on the timeout cycle of every layer
    stub_lat = TIMEOUT;
    e0 = err_cnt;
    launch(32'h0000_0400, 6000, lat);
    chk("t5_lat", lat, 3 * (1 + TIMEOUT) + 1);
    chk("t5_outq", out_q, 32'h0000_0403);
    chk("t5_cycles", cycles, 3 * (1 + TIMEOUT) + 1);
    chk("t5_no_err", err_cnt - e0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    stub_lat = 8;

    // 6: async reset mid-RUN, then spurious valid in IDLE
    in_d = 32'h0000_0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run(4'd2, 100, ok);
    chk("t6_reach_l2", ok, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_run", mix_run, 0);
    chk("t6_state", mix_state, 0);
    chk("t6_buf", mix_d, 0);
    chk("t6_ready", start_ready, 1);
    chk("t6_cycles", cycles, 0);
    #1 rst = 1'b0;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_spur_run", mix_run, 0);
      chk("t6_spur_ovld", out_valid, 0);
      chk("t6_spur_outq", out_q, 0);
    end
    spur = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
